// File: rtl/dllp_transmit.sv
// DLLP transmitter. Arbitrates Ack/Nak, InitFC1/2 and UpdateFC sources and sends each
// winner as a 2-beat AXI-Stream packet: 4-byte body, then the 16-bit DLLP CRC.
module dllp_transmit #(
    parameter int DATA_WIDTH       = 32,
    parameter int KEEP_WIDTH       = DATA_WIDTH/8,
    parameter int USER_WIDTH       = 4,
    parameter int FC_INIT_GAP      = 16,
    parameter int UPDATE_FC_PERIOD = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  phy_link_up_i,
    input  logic                  ack_nak_vld_i,
    output logic                  ack_nak_rdy_o,
    input  logic                  ack_nak_type_i,
    input  logic [11:0]           ack_nak_seq_i,
    input  logic                  fc_init1_i,
    input  logic                  fc_init2_i,
    output logic                  fc_init_set_done_o,
    input  logic [2:0]            update_fc_req_i,
    input  logic [7:0]            rx_fc_ph_i,
    input  logic [7:0]            rx_fc_nph_i,
    input  logic [7:0]            rx_fc_cplh_i,
    input  logic [11:0]           rx_fc_pd_i,
    input  logic [11:0]           rx_fc_npd_i,
    input  logic [11:0]           rx_fc_cpld_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND_DLLP, ST_SEND_CRC} state_t;

    localparam int PER_W = (UPDATE_FC_PERIOD > 2) ? $clog2(UPDATE_FC_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(UPDATE_FC_PERIOD - 1);

    // Poly 0x100B, bits consumed byte0 bit0 first, result complemented.
    function automatic logic [15:0] pcie_datalink_crc(input logic [15:0] crc_in,
                                                     input logic [31:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h100B;
        end
        return ~c;
    endfunction

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [KEEP_WIDTH-1:0]   tkeep_q;
    logic [USER_WIDTH-1:0]   tuser_q;
    logic                    tvalid_q, tlast_q, done_q, is_init_q;
    logic [15:0]             crc_q, crc_d;
    logic [1:0]              idx_q;
    logic [15:0]             gap_q;
    logic [PER_W-1:0]        per_q;
    logic [2:0]              pending_q, pending_d;

    logic        init_act, init_ok, idle_up;
    logic        take_ack, take_init, take_upd, take_any, per_exp;
    logic [1:0]  sel;
    logic [1:0]  prefix;
    logic [7:0]  hdr, ack_type;
    logic [11:0] dat;
    logic [2:0]  upd_clr;
    logic [31:0] body_d;

    assign init_act  = fc_init1_i | fc_init2_i;
    assign init_ok   = init_act && (gap_q == 16'd0);
    assign idle_up   = (state_q == ST_IDLE) && phy_link_up_i;
    assign ack_nak_rdy_o = idle_up && !rst_i;
    assign take_ack  = ack_nak_vld_i && idle_up;
    assign take_init = idle_up && !ack_nak_vld_i && init_ok;
    assign take_upd  = idle_up && !ack_nak_vld_i && !init_act && (pending_q != 3'b000);
    assign take_any  = take_ack || take_init || take_upd;
    assign per_exp   = !init_act && (per_q == PER_MAX);

    // InitFC walks the index; UpdateFC takes the lowest pending class (P > NP > Cpl).
    always_comb begin
        sel = 2'd2;
        if (init_ok)           sel = idx_q;
        else if (pending_q[0]) sel = 2'd0;
        else if (pending_q[1]) sel = 2'd1;
        case (sel)
            2'd0:    begin hdr = rx_fc_ph_i;   dat = rx_fc_pd_i;   end
            2'd1:    begin hdr = rx_fc_nph_i;  dat = rx_fc_npd_i;  end
            default: begin hdr = rx_fc_cplh_i; dat = rx_fc_cpld_i; end
        endcase
        prefix   = init_ok ? (fc_init2_i ? 2'b11 : 2'b01) : 2'b10;
        ack_type = ack_nak_type_i ? 8'h00 : 8'h10;
        if (take_ack)
            body_d = {ack_nak_seq_i[7:0], 4'h0, ack_nak_seq_i[11:8], 8'h00, ack_type};
        else
            body_d = {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2],
                      prefix, sel, 4'h0};
        crc_d     = pcie_datalink_crc(16'hFFFF, body_d);
        upd_clr   = take_upd ? (3'b001 << sel) : 3'b000;
        pending_d = (pending_q & ~upd_clr) | update_fc_req_i | (per_exp ? 3'b111 : 3'b000);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !phy_link_up_i) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            is_init_q <= 1'b0;
            crc_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            per_q     <= '0;
            pending_q <= '0;
        end else begin
            done_q    <= 1'b0;
            pending_q <= pending_d;
            if (gap_q != 16'd0) gap_q <= gap_q - 16'd1;
            if (!init_act) per_q <= per_exp ? '0 : per_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (!init_act) idx_q <= '0;
                    if (take_any) begin
                        tdata_q   <= body_d;
                        tkeep_q   <= '1;
                        tuser_q   <= USER_WIDTH'(1);
                        tlast_q   <= 1'b0;
                        tvalid_q  <= 1'b1;
                        crc_q     <= crc_d;
                        is_init_q <= take_init;
                        state_q   <= ST_SEND_DLLP;
                    end
                end
                ST_SEND_DLLP: begin
                    if (m_axis_tready) begin
                        tdata_q <= {16'h0000, crc_q};
                        tkeep_q <= KEEP_WIDTH'(4'b0011);
                        tlast_q <= 1'b1;
                        state_q <= ST_SEND_CRC;
                    end
                end
                ST_SEND_CRC: begin
                    if (m_axis_tready) begin
                        tdata_q  <= '0;
                        tkeep_q  <= '0;
                        tuser_q  <= '0;
                        tlast_q  <= 1'b0;
                        tvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (is_init_q) begin
                            if (idx_q == 2'd2) begin
                                idx_q  <= '0;
                                gap_q  <= 16'(FC_INIT_GAP);
                                done_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 2'd1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata       = tdata_q;
    assign m_axis_tkeep       = tkeep_q;
    assign m_axis_tuser       = tuser_q;
    assign m_axis_tvalid      = tvalid_q;
    assign m_axis_tlast       = tlast_q;
    assign fc_init_set_done_o = done_q;

endmodule

// File: tb/tb_dllp_transmit.sv
// Directed bench for dllp_transmit: Ack/Nak encoding, InitFC sequencing and gap,
// arbitration order, backpressure, link-down flush and periodic UpdateFC.
module tb_dllp_transmit;

    localparam int GAP = 16;
    localparam int PER = 200;

    logic        clk = 1'b0;
    logic        rst, link, vld, typ, init1, init2, rdy, done, tready;
    logic [11:0] seq;
    logic [2:0]  upd;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    logic [31:0] tdata;
    logic [3:0]  tkeep, tuser;
    logic        tvalid, tlast;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dllp_transmit #(.FC_INIT_GAP(GAP), .UPDATE_FC_PERIOD(PER)) dut (
        .clk_i(clk), .rst_i(rst), .phy_link_up_i(link),
        .ack_nak_vld_i(vld), .ack_nak_rdy_o(rdy), .ack_nak_type_i(typ), .ack_nak_seq_i(seq),
        .fc_init1_i(init1), .fc_init2_i(init2), .fc_init_set_done_o(done),
        .update_fc_req_i(upd),
        .rx_fc_ph_i(ph), .rx_fc_nph_i(nph), .rx_fc_cplh_i(cplh),
        .rx_fc_pd_i(pd), .rx_fc_npd_i(npd), .rx_fc_cpld_i(cpld),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .m_axis_tready(tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference CRC as polynomial long division of (seed*x^32 + M*x^16) by x^16+x^12+x^3+x+1.
    function automatic logic [15:0] ref_crc(input logic [31:0] data);
        logic [47:0] v;
        logic [31:0] m;
        for (int k = 0; k < 32; k++) m[31-k] = data[k];
        v = {16'hFFFF, 32'h0} ^ {m, 16'h0};
        for (int j = 47; j >= 16; j--)
            if (v[j]) v = v ^ (48'h1_100B << (j - 16));
        return ~v[15:0];
    endfunction

    task automatic get_beat0(input int limit, output logic [31:0] d, output int at, output bit ok);
        ok = 1'b0; d = '0; at = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (tvalid && !tlast) begin ok = 1'b1; d = tdata; at = cyc; end
        end
    endtask

    task automatic link_flush();
        @(negedge clk); link = 1'b0; vld = 1'b0; upd = 3'b000;
        @(negedge clk);
        @(negedge clk); link = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; link = 1'b1; vld = 1'b1; typ = 1'b1; seq = 12'h0;
        repeat (3) @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
        checks++; if ({tdata, tkeep, tuser, tlast, done} !== 41'h0) begin errors++; $display("FAIL reset_outs got %h/%h/%h/%b/%b want 0", tdata, tkeep, tuser, tlast, done); end
        vld = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (rdy !== 1'b1 || tvalid !== 1'b0) begin errors++; $display("FAIL post_reset rdy=%b tvalid=%b want 1/0", rdy, tvalid); end
    endtask

    task automatic test_ack_nak();
        tready = 1'b1;
        @(negedge clk); vld = 1'b1; typ = 1'b1; seq = 12'h123;
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h2301_0000) begin errors++; $display("FAIL ack_beat0 got v=%b d=%h want 1/23010000", tvalid, tdata); end
        checks++; if (tuser !== 4'b0001 || tlast !== 1'b0 || tkeep !== 4'hF) begin errors++; $display("FAIL ack_beat0_side got u=%h l=%b k=%h want 1/0/f", tuser, tlast, tkeep); end
        vld = 1'b0;
        @(negedge clk);
        checks++; if (tdata !== {16'h0, ref_crc(32'h2301_0000)}) begin errors++; $display("FAIL ack_crc got %h want %h", tdata, {16'h0, ref_crc(32'h2301_0000)}); end
        checks++; if (tkeep !== 4'b0011 || tlast !== 1'b1 || tuser !== 4'b0001) begin errors++; $display("FAIL ack_beat1_side got k=%h l=%b u=%h want 3/1/1", tkeep, tlast, tuser); end
        @(negedge clk);
        checks++; if (tvalid !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL ack_idle got v=%b rdy=%b want 0/1", tvalid, rdy); end
        vld = 1'b1; typ = 1'b0; seq = 12'hABC;
        @(negedge clk);
        checks++; if (tdata !== 32'hBC0A_0010) begin errors++; $display("FAIL nak_beat0 got %h want bc0a0010", tdata); end
        vld = 1'b0;
        @(negedge clk);
        checks++; if (tdata !== {16'h0, ref_crc(32'hBC0A_0010)}) begin errors++; $display("FAIL nak_crc got %h want %h", tdata, {16'h0, ref_crc(32'hBC0A_0010)}); end
    endtask

    task automatic test_initfc();
        logic [31:0] d; int at, c_idle; bit ok;
        link_flush();
        ph = 8'h20; pd = 12'h100; nph = 8'h11; npd = 12'h234; cplh = 8'hFF; cpld = 12'hFFF;
        init1 = 1'b1;
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'h0001_0840) begin errors++; $display("FAIL init1_p got ok=%b d=%h want 00010840", ok, d); end
        @(negedge clk);
        checks++; if (tdata !== {16'h0, ref_crc(32'h0001_0840)}) begin errors++; $display("FAIL init1_p_crc got %h want %h", tdata, {16'h0, ref_crc(32'h0001_0840)}); end
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'h3442_0450) begin errors++; $display("FAIL init1_np got ok=%b d=%h want 34420450", ok, d); end
        @(negedge clk); @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_after_np got %b want 0", done); end
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'hFFCF_3F60) begin errors++; $display("FAIL init1_cpl got ok=%b d=%h want ffcf3f60", ok, d); end
        @(negedge clk); @(negedge clk);
        checks++; if (done !== 1'b1 || tvalid !== 1'b0) begin errors++; $display("FAIL set_done got done=%b v=%b want 1/0", done, tvalid); end
        c_idle = cyc;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
        get_beat0(40, d, at, ok);
        checks++; if (!ok || at - c_idle != GAP + 1 || d !== 32'h0001_0840) begin errors++; $display("FAIL init_gap got ok=%b dist=%0d d=%h want %0d/00010840", ok, at - c_idle, d, GAP + 1); end
        link_flush();
        init2 = 1'b1;
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'h0001_08C0) begin errors++; $display("FAIL init2_p got ok=%b d=%h want 000108c0", ok, d); end
        init1 = 1'b0; init2 = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] d; int at; bit ok;
        logic [7:0] exp_t [6];
        exp_t[0] = 8'h40; exp_t[1] = 8'h50; exp_t[2] = 8'h60; exp_t[3] = 8'h40;
        exp_t[4] = 8'h90; exp_t[5] = 8'hA0;
        link_flush();
        ph = 8'h20; pd = 12'h100;
        vld = 1'b1; typ = 1'b1; seq = 12'h005; init1 = 1'b1; upd = 3'b111;
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0500_0000) begin errors++; $display("FAIL prio_ack got v=%b d=%h want 1/05000000", tvalid, tdata); end
        vld = 1'b0; upd = 3'b000;
        for (int i = 0; i < 4; i++) begin
            get_beat0(40, d, at, ok);
            checks++; if (!ok || d[7:0] !== exp_t[i]) begin errors++; $display("FAIL prio_init%0d got ok=%b type=%h want %h", i, ok, d[7:0], exp_t[i]); end
        end
        init1 = 1'b0;
        get_beat0(20, d, at, ok);
        checks++; if (!ok || d !== 32'h0001_0880) begin errors++; $display("FAIL prio_upd_p got ok=%b d=%h want 00010880", ok, d); end
        for (int i = 4; i < 6; i++) begin
            get_beat0(20, d, at, ok);
            checks++; if (!ok || d[7:0] !== exp_t[i]) begin errors++; $display("FAIL prio_upd%0d got ok=%b type=%h want %h", i, ok, d[7:0], exp_t[i]); end
        end
        get_beat0(20, d, at, ok);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL prio_extra got extra beat %h want none", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        link_flush();
        tready = 1'b0;
        vld = 1'b1; typ = 1'b0; seq = 12'hABC;
        @(negedge clk);
        vld = 1'b0;
        held = 32'hBC0A_0010;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tvalid !== 1'b1 || tdata !== held || tlast !== 1'b0 || tkeep !== 4'hF) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b k=%h want 1/%h/0/f", i, tvalid, tdata, tlast, tkeep, held); end
            if (i < 4) @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        checks++; if (tlast !== 1'b1 || tdata !== {16'h0, ref_crc(held)}) begin errors++; $display("FAIL bp_beat1 got l=%b d=%h want 1/%h", tlast, tdata, {16'h0, ref_crc(held)}); end
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tlast !== 1'b1) begin errors++; $display("FAIL bp_beat1_hold got v=%b l=%b want 1/1", tvalid, tlast); end
        tready = 1'b1;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_release got v=%b want 0", tvalid); end
    endtask

    task automatic test_link_down();
        bit quiet;
        link_flush();
        vld = 1'b1; typ = 1'b1; seq = 12'h7FF; upd = 3'b110;
        @(negedge clk);
        vld = 1'b0; upd = 3'b000;
        @(negedge clk);
        checks++; if (tlast !== 1'b1 || tvalid !== 1'b1) begin errors++; $display("FAIL ld_beat1 got v=%b l=%b want 1/1", tvalid, tlast); end
        link = 1'b0;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0 || rdy !== 1'b0 || tlast !== 1'b0) begin errors++; $display("FAIL ld_flush got v=%b rdy=%b l=%b want 0/0/0", tvalid, rdy, tlast); end
        link = 1'b1;
        @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ld_rdy_back got %b want 1", rdy); end
        quiet = 1'b1;
        repeat (20) begin @(negedge clk); if (tvalid !== 1'b0) quiet = 1'b0; end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL ld_pending_cleared got traffic after relink want none"); end
    endtask

    task automatic test_periodic();
        logic [31:0] d; int at, c0, atp; bit ok;
        ph = 8'h0A; pd = 12'h05A; nph = 8'h01; npd = 12'h000; cplh = 8'h80; cpld = 12'h800;
        link_flush();
        c0 = cyc;
        get_beat0(PER + 50, d, at, ok);
        checks++; if (!ok || at - c0 != PER + 1 || d !== 32'h5A80_0280) begin errors++; $display("FAIL per_p got ok=%b dist=%0d d=%h want %0d/5a800280", ok, at - c0, d, PER + 1); end
        atp = at;
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'h0040_0090) begin errors++; $display("FAIL per_np got ok=%b d=%h want 00400090", ok, d); end
        get_beat0(10, d, at, ok);
        checks++; if (!ok || d !== 32'h0008_20A0) begin errors++; $display("FAIL per_cpl got ok=%b d=%h want 000820a0", ok, d); end
        ph = 8'hFF; pd = 12'hFFF;
        get_beat0(PER + 50, d, at, ok);
        checks++; if (!ok || at - atp != PER || d !== 32'hFFCF_3F80) begin errors++; $display("FAIL per_p2 got ok=%b dist=%0d d=%h want %0d/ffcf3f80", ok, at - atp, d, PER); end
    endtask

    initial begin
        rst = 1'b1; link = 1'b0; vld = 1'b0; typ = 1'b0; seq = '0;
        init1 = 1'b0; init2 = 1'b0; upd = '0; tready = 1'b1;
        ph = '0; nph = '0; cplh = '0; pd = '0; npd = '0; cpld = '0;
        test_reset();
        test_ack_nak();
        test_initfc();
        test_priority();
        test_backpressure();
        test_link_down();
        test_periodic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
